// File: rtl/comb_pipe_test_if.sv
// Handshake and result bus for comb_pipe_test: input valid/ready with sources,
// output valid/ready with the FIFO head results and the pop counter.
interface comb_pipe_test_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned LANES = 2
);
  localparam int unsigned W = SIZE * LANES;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [W-1:0] src3;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
  logic [W-1:0] out4;
  logic [W-1:0] out5;
  logic [15:0]  pop_count;

  // Producer/consumer side
  modport master (
    output in_valid, mode, src1, src2, src3, out_ready,
    input  in_ready, out_valid, out1, out2, out3, out4, out5, pop_count
  );

  // Block side
  modport slave (
    input  in_valid, mode, src1, src2, src3, out_ready,
    output in_ready, out_valid, out1, out2, out3, out4, out5, pop_count
  );
endinterface

// File: rtl/comb_pipe_test.sv
// Pipelined multi-lane select/priority block: one input register stage feeding
// a DEPTH-entry in-order result FIFO, with operand swap and out5 accumulate modes.
module comb_pipe_test #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  comb_pipe_test_if.slave bus
);
  localparam int unsigned W     = SIZE * LANES;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_SWAP = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;

  typedef struct packed {
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [W-1:0] o3;
    logic [W-1:0] o4;
    logic [W-1:0] o5;
  } result_t;

  // Stage S1
  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [W-1:0]     s1_c;

  // Result FIFO
  result_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [W-1:0]     acc_q;
  logic [15:0]      pop_count_q;

  // Combinational control and datapath
  logic             out_valid_c;
  logic             pop_c;
  logic             move_c;
  logic             in_ready_c;
  result_t          fn_c;
  logic [W-1:0]     acc_next_c;
  logic [SIZE-1:0]  la_c;
  logic [SIZE-1:0]  lb_c;
  logic [SIZE-1:0]  lc_c;
  logic [2:0]       lsbs_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake: a move frees S1, so in_ready depends only on state and out_ready
  always_comb begin
    out_valid_c = (count != '0);
    pop_c       = out_valid_c && bus.out_ready;
    move_c      = s1_valid && ((count < CNT_W'(DEPTH)) || pop_c);
    in_ready_c  = !s1_valid || move_c;
  end

  // Per-lane select function on S1 contents, plus the accumulate update
  always_comb begin
    fn_c       = '0;
    acc_next_c = acc_q;
    la_c       = '0;
    lb_c       = '0;
    lc_c       = '0;
    lsbs_c     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (s1_mode == MODE_SWAP) begin
        la_c = s1_b[i*SIZE +: SIZE];
        lb_c = s1_a[i*SIZE +: SIZE];
      end else begin
        la_c = s1_a[i*SIZE +: SIZE];
        lb_c = s1_b[i*SIZE +: SIZE];
      end
      lc_c   = s1_c[i*SIZE +: SIZE];
      lsbs_c = {lc_c[0], lb_c[0], la_c[0]};
      if (la_c < lb_c) begin
        fn_c.o3[i*SIZE +: SIZE] = lb_c;
        fn_c.o5[i*SIZE +: SIZE] = lc_c;
        if (lsbs_c == 3'd1) begin
          fn_c.o1[i*SIZE +: SIZE] = lc_c;
          fn_c.o2[i*SIZE +: SIZE] = lc_c;
          fn_c.o4[i*SIZE +: SIZE] = lc_c;
        end else if (lsbs_c == 3'd3) begin
          fn_c.o1[i*SIZE +: SIZE] = la_c;
          fn_c.o2[i*SIZE +: SIZE] = lb_c;
          fn_c.o3[i*SIZE +: SIZE] = '0;
          fn_c.o4[i*SIZE +: SIZE] = '0;
        end else begin
          fn_c.o1[i*SIZE +: SIZE] = la_c;
          fn_c.o2[i*SIZE +: SIZE] = lb_c;
          fn_c.o4[i*SIZE +: SIZE] = la_c;
        end
      end else begin
        fn_c.o1[i*SIZE +: SIZE] = la_c;
        fn_c.o2[i*SIZE +: SIZE] = lb_c;
        fn_c.o3[i*SIZE +: SIZE] = la_c;
        fn_c.o4[i*SIZE +: SIZE] = lb_c;
        fn_c.o5[i*SIZE +: SIZE] = la_c;
      end
      if (s1_mode == MODE_ACC) begin
        acc_next_c[i*SIZE +: SIZE] = acc_q[i*SIZE +: SIZE] + fn_c.o5[i*SIZE +: SIZE];
        fn_c.o5[i*SIZE +: SIZE]    = acc_next_c[i*SIZE +: SIZE];
      end
    end
  end

  // S1 stage: loads on accept, empties when its contents move on
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= bus.mode;
        s1_a    <= bus.src1;
        s1_b    <= bus.src2;
        s1_c    <= bus.src3;
      end
    end
  end

  // FIFO storage; contents are don't-care while their slot is not counted
  always_ff @(posedge clk) begin
    if (move_c) begin
      mem[wr_ptr] <= fn_c;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (move_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (move_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (!move_c && pop_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Accumulators advance only on mode-2 moves
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (move_c && (s1_mode == MODE_ACC)) begin
      acc_q <= acc_next_c;
    end
  end

  // Completed pop counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_count_q <= '0;
    end else if (pop_c) begin
      pop_count_q <= pop_count_q + 16'd1;
    end
  end

  // Head presentation: zeros while empty
  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_c;
    bus.pop_count = pop_count_q;
    bus.out1      = '0;
    bus.out2      = '0;
    bus.out3      = '0;
    bus.out4      = '0;
    bus.out5      = '0;
    if (out_valid_c) begin
      bus.out1 = mem[rd_ptr].o1;
      bus.out2 = mem[rd_ptr].o2;
      bus.out3 = mem[rd_ptr].o3;
      bus.out4 = mem[rd_ptr].o4;
      bus.out5 = mem[rd_ptr].o5;
    end
  end
endmodule

// File: tb/tb_comb_pipe_test.sv
// Directed bench for comb_pipe_test (SIZE=4, LANES=2, DEPTH=2).
module tb_comb_pipe_test;
  localparam int unsigned SIZE  = 4;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned W     = SIZE * LANES;
  localparam int          NV    = 12;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] s1, s2, s3;
    logic [W-1:0] e1, e2, e3, e4, e5;
  } vec_t;

  vec_t        vecs [NV];
  logic        clk;
  logic        reset;
  int          checks;
  int          failures;
  logic [15:0] pc_exp;

  comb_pipe_test_if #(.SIZE(SIZE), .LANES(LANES)) bus ();

  comb_pipe_test #(.SIZE(SIZE), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] m,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic [W-1:0] o1, input logic [W-1:0] o2, input logic [W-1:0] o3,
                              input logic [W-1:0] o4, input logic [W-1:0] o5);
    vec_t v;
    v.mode = m; v.s1 = a; v.s2 = b; v.s3 = c;
    v.e1 = o1; v.e2 = o2; v.e3 = o3; v.e4 = o4; v.e5 = o5;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int idx);
    bus.mode = vecs[idx].mode;
    bus.src1 = vecs[idx].s1;
    bus.src2 = vecs[idx].s2;
    bus.src3 = vecs[idx].s3;
  endtask

  task automatic check_head(input int idx, input string tag);
    check({tag, ".out1"}, 32'(bus.out1), 32'(vecs[idx].e1));
    check({tag, ".out2"}, 32'(bus.out2), 32'(vecs[idx].e2));
    check({tag, ".out3"}, 32'(bus.out3), 32'(vecs[idx].e3));
    check({tag, ".out4"}, 32'(bus.out4), 32'(vecs[idx].e4));
    check({tag, ".out5"}, 32'(bus.out5), 32'(vecs[idx].e5));
  endtask

  // Single transaction: accept, wait for head, compare, pop
  task automatic run_row(input int idx);
    int g;
    string tag;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    drive(idx);
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_head(idx, tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    pc_exp++;
    @(negedge clk);
    check({tag, ".pop_count"}, 32'(bus.pop_count), 32'(pc_exp));
  endtask

  initial begin
    int bp [3];
    int stalls;
    checks   = 0;
    failures = 0;
    pc_exp   = '0;

    // Lane values packed {lane1, lane0}
    vecs[0]  = mk(2'd0, 8'h22, 8'h55, 8'h11, 8'h22, 8'h55, 8'h55, 8'h22, 8'h11);
    vecs[1]  = mk(2'd0, 8'h11, 8'h44, 8'h66, 8'h66, 8'h66, 8'h44, 8'h66, 8'h66);
    vecs[2]  = mk(2'd0, 8'h11, 8'h33, 8'h88, 8'h11, 8'h33, 8'h00, 8'h00, 8'h88);
    vecs[3]  = mk(2'd0, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'h99);
    vecs[4]  = mk(2'd1, 8'h99, 8'h33, 8'h77, 8'h33, 8'h99, 8'h99, 8'h33, 8'h77);
    vecs[5]  = mk(2'd0, 8'h92, 8'h35, 8'h71, 8'h92, 8'h35, 8'h95, 8'h32, 8'h91);
    vecs[6]  = mk(2'd2, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'h99);
    vecs[7]  = mk(2'd2, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'h22);
    vecs[8]  = mk(2'd0, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'h99);
    vecs[9]  = mk(2'd2, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'hbb);
    vecs[10] = mk(2'd3, 8'h99, 8'h33, 8'h77, 8'h99, 8'h33, 8'h99, 8'h33, 8'h99);
    vecs[11] = mk(2'd0, 8'h55, 8'h55, 8'h22, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.src3      = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.pop_count", 32'(bus.pop_count), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out1", 32'(bus.out1), 32'd0);
    check("rst.out5", 32'(bus.out5), 32'd0);

    // Latency: accept at edge k, head valid after edge k+1
    drive(0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat.k_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat.k1_out_valid", 32'(bus.out_valid), 32'd1);
    check_head(0, "lat");
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    pc_exp++;
    @(negedge clk);
    check("lat.pop_count", 32'(bus.pop_count), 32'(pc_exp));

    // Table of single transactions (accumulator state carries across rows)
    for (int i = 0; i < NV; i++) begin
      run_row(i);
    end

    // Back-pressure: S1 plus two FIFO entries fill, then in_ready drops
    bp[0] = 1; bp[1] = 2; bp[2] = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(bp[k]);
      bus.in_valid = 1'b1;
      check($sformatf("bp.accept%0d_ready", k), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    check("bp.full_ready", 32'(bus.in_ready), 32'd0);
    check_head(bp[0], "bp.head");
    repeat (3) @(negedge clk);
    check("bp.hold_ready", 32'(bus.in_ready), 32'd0);
    check("bp.hold_valid", 32'(bus.out_valid), 32'd1);
    check_head(bp[0], "bp.stable");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp.ready_on_pop", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp.drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check_head(bp[k], $sformatf("bp.drain%0d", k));
      @(posedge clk);
      pc_exp++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("bp.empty", 32'(bus.out_valid), 32'd0);
    check("bp.pop_count", 32'(bus.pop_count), 32'(pc_exp));

    // Reset with FIFO full and accumulators nonzero
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(6);
      bus.in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("mr.prefull_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    pc_exp = '0;
    @(negedge clk);
    check("mr.out_valid", 32'(bus.out_valid), 32'd0);
    check("mr.pop_count", 32'(bus.pop_count), 32'd0);
    check("mr.in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("mr.nothing_survives", 32'(bus.out_valid), 32'd0);
    run_row(6);

    // Full throughput streaming up to and across the pop_count wrap
    @(negedge clk);
    drive(3);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    stalls = 0;
    while (pc_exp != 16'hFFFF) begin
      if (!bus.out_valid) stalls++;
      @(posedge clk);
      pc_exp++;
      @(negedge clk);
    end
    check("tp.stalls", 32'(stalls), 32'd0);
    check("tp.pop_count_ffff", 32'(bus.pop_count), 32'h0000FFFF);
    check_head(3, "tp");
    @(posedge clk);
    pc_exp++;
    @(negedge clk);
    check("tp.pop_count_wrap", 32'(bus.pop_count), 32'(pc_exp));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
